// File: rtl/boot_supervisor.sv
// Board reset sequencer driven by watchdog bites.
// Counts failed boots and latches recovery mode after MAX_TRIES.
module boot_supervisor #(
    parameter logic [4:0] BASE_ADDR     = 5'h0,
    parameter logic [7:0] DEFAULT_PULSE = 8'd16,
    parameter logic [2:0] MAX_TRIES     = 3'd3,
    parameter logic [7:0] BOOT_OK_MAGIC = 8'h5a
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    input  logic       wdt_bite_in,
    output logic       board_rst,
    output logic       recovery,
    output logic       irq
);

    typedef enum logic [1:0] {
        S_RUN,
        S_ASSERT,
        S_RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic        board_rst_q, board_rst_d;
    logic        recovery_q, recovery_d;
    logic        irq_q, irq_d;
    logic        en_q, en_d;
    logic [2:0]  tries_q, tries_d;
    logic [7:0]  pulse_q, pulse_d;
    logic        cause_q, cause_d;
    logic        prev_q;
    logic [7:0]  cnt_q, cnt_d;

    logic [4:0]  off;
    logic        hit;
    logic        wr_ctrl, wr_tries, wr_pulse, wr_cause;
    logic [2:0]  tries_base;
    logic [3:0]  tries_inc;

    assign off      = csr_a - BASE_ADDR;
    assign hit      = (off < 5'd4);
    assign wr_ctrl  = csr_we && hit && (off[1:0] == 2'd0);
    assign wr_tries = csr_we && hit && (off[1:0] == 2'd1);
    assign wr_pulse = csr_we && hit && (off[1:0] == 2'd2);
    assign wr_cause = csr_we && hit && (off[1:0] == 2'd3);

    // Magic clear lands before a coincident bite increments.
    assign tries_base = (wr_tries && csr_di == BOOT_OK_MAGIC) ? 3'd0 : tries_q;
    assign tries_inc  = {1'b0, tries_base} + 4'd1;

    always_comb begin
        state_d     = state_q;
        board_rst_d = board_rst_q;
        recovery_d  = recovery_q;
        irq_d       = 1'b0;
        en_d        = en_q;
        tries_d     = tries_base;
        pulse_d     = pulse_q;
        cause_d     = cause_q;
        cnt_d       = cnt_q;

        if (wr_ctrl) begin
            en_d       = csr_di[0];
            recovery_d = csr_di[1];
        end
        if (wr_pulse) begin
            pulse_d = csr_di;
        end
        if (wr_cause && csr_di[0]) begin
            cause_d = 1'b0;
        end

        unique case (state_q)
            S_RUN: begin
                if (wdt_bite_in && !prev_q && en_q) begin
                    state_d     = S_ASSERT;
                    board_rst_d = 1'b1;
                    irq_d       = 1'b1;
                    cnt_d       = (pulse_q == 8'd0) ? 8'd1 : pulse_q;
                    tries_d     = tries_inc[3] ? 3'd7 : tries_inc[2:0];
                    cause_d     = 1'b1;
                    if (tries_inc >= {1'b0, MAX_TRIES}) begin
                        recovery_d = 1'b1;
                    end
                end
            end
            S_ASSERT: begin
                if (ce) begin
                    if (cnt_q == 8'd1) begin
                        board_rst_d = 1'b0;
                        state_d     = S_RELEASE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            S_RELEASE: begin
                if (!wdt_bite_in) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            board_rst_q <= 1'b0;
            recovery_q  <= 1'b0;
            irq_q       <= 1'b0;
            en_q        <= 1'b1;
            tries_q     <= 3'd0;
            pulse_q     <= DEFAULT_PULSE;
            cause_q     <= 1'b0;
            prev_q      <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            board_rst_q <= board_rst_d;
            recovery_q  <= recovery_d;
            irq_q       <= irq_d;
            en_q        <= en_d;
            tries_q     <= tries_d;
            pulse_q     <= pulse_d;
            cause_q     <= cause_d;
            prev_q      <= wdt_bite_in;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        csr_do = 8'd0;
        if (hit) begin
            unique case (off[1:0])
                2'd0: csr_do = {6'd0, recovery_q, en_q};
                2'd1: csr_do = {5'd0, tries_q};
                2'd2: csr_do = pulse_q;
                2'd3: csr_do = {7'd0, cause_q};
                default: csr_do = 8'd0;
            endcase
        end
    end

    assign board_rst = board_rst_q;
    assign recovery  = recovery_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_boot_supervisor.sv
// Scoreboard bench for boot_supervisor: pulse widths and try counts
// are queued at each bite and checked when the board reset falls.
module tb_boot_supervisor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic [4:0] csr_a = 5'd0;
    logic [7:0] csr_di = 8'd0;
    logic       csr_we = 1'b0;
    logic [7:0] csr_do;
    logic       wdt = 1'b0;
    logic       board_rst, recovery, irq;

    int nvec = 0;
    int nmis = 0;
    int irq_cnt = 0;
    int ce_hi = 0;
    int seq_start = 0;
    int exp_w[$];
    logic [2:0] exp_t[$];

    boot_supervisor dut (
        .clk(clk), .rst(rst), .ce(ce),
        .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
        .csr_do(csr_do), .wdt_bite_in(wdt),
        .board_rst(board_rst), .recovery(recovery), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin : cegen
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            ce = (n % 4 == 0);
        end
    end

    always @(negedge clk) begin
        if (irq) irq_cnt <= irq_cnt + 1;
        if (board_rst && ce) ce_hi <= ce_hi + 1;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        csr_a = a; csr_di = d; csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        csr_a = a;
        #1;
        d = csr_do;
    endtask

    task automatic raise(input int w, input logic [2:0] t);
        exp_w.push_back(w);
        exp_t.push_back(t);
        wdt = 1'b1;
        tick();
        seq_start = ce_hi;
    endtask

    task automatic finish_seq(input string name);
        int w;
        logic [2:0] t;
        logic [7:0] v;
        bit done;
        done = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!board_rst) begin
                done = 1;
                break;
            end
        end
        w = exp_w.pop_front();
        t = exp_t.pop_front();
        nvec++;
        if (!done) begin
            nmis++;
            $display("FAIL %s timeout: board_rst still %b after 3000 clk, want 0", name, board_rst);
        end else if (ce_hi - seq_start != w) begin
            nmis++;
            $display("FAIL %s width: got %0d ce ticks, want %0d", name, ce_hi - seq_start, w);
        end
        rd(5'd1, v);
        nvec++;
        if (v !== {5'd0, t}) begin
            nmis++;
            $display("FAIL %s tries: got %h want %h", name, v, {5'd0, t});
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        nvec++;
        if ({board_rst, recovery, irq} !== 3'b000) begin
            nmis++;
            $display("FAIL reset_out: got %b want 000", {board_rst, recovery, irq});
        end
        rd(5'd0, v); nvec++;
        if (v !== 8'h01) begin nmis++; $display("FAIL reset_ctrl: got %h want 01", v); end
        rd(5'd1, v); nvec++;
        if (v !== 8'h00) begin nmis++; $display("FAIL reset_tries: got %h want 00", v); end
        rd(5'd2, v); nvec++;
        if (v !== 8'd16) begin nmis++; $display("FAIL reset_pulse: got %h want 10", v); end
        rd(5'd3, v); nvec++;
        if (v !== 8'h00) begin nmis++; $display("FAIL reset_cause: got %h want 00", v); end
        rd(5'd4, v); nvec++;
        if (v !== 8'h00) begin nmis++; $display("FAIL unmapped: got %h want 00", v); end
    endtask

    task automatic test_basic();
        logic [7:0] v;
        raise(16, 3'd1);
        nvec++;
        if ({irq, board_rst} !== 2'b11) begin
            nmis++;
            $display("FAIL basic_irq: got irq,rst=%b want 11", {irq, board_rst});
        end
        finish_seq("basic");
        wdt = 1'b0;
        tick(2);
        nvec++;
        if (irq_cnt !== 1) begin nmis++; $display("FAIL basic_irqcnt: got %0d want 1", irq_cnt); end
        rd(5'd3, v); nvec++;
        if (v !== 8'h01) begin nmis++; $display("FAIL basic_cause: got %h want 01", v); end
        rd(5'd0, v); nvec++;
        if (v !== 8'h01) begin nmis++; $display("FAIL basic_ctrl: got %h want 01", v); end
        wr(5'd3, 8'h01);
        rd(5'd3, v); nvec++;
        if (v !== 8'h00) begin nmis++; $display("FAIL cause_w1c: got %h want 00", v); end
    endtask

    task automatic test_recovery();
        logic [7:0] v;
        wr(5'd1, 8'h5a);
        for (int i = 0; i < 3; i++) begin
            raise(16, 3'(i + 1));
            finish_seq("recov");
            wdt = 1'b0;
            tick(2);
            nvec++;
            if (recovery !== (i == 2)) begin
                nmis++;
                $display("FAIL recov_latch%0d: got %b want %b", i, recovery, i == 2);
            end
        end
        wr(5'd0, 8'h01);
        nvec++;
        if (recovery !== 1'b0) begin nmis++; $display("FAIL recov_clear: got %b want 0", recovery); end
        rd(5'd1, v); nvec++;
        if (v !== 8'h03) begin nmis++; $display("FAIL recov_tries: got %h want 03", v); end
        wr(5'd1, 8'h5a);
        rd(5'd1, v); nvec++;
        if (v !== 8'h00) begin nmis++; $display("FAIL magic_clear: got %h want 00", v); end
    endtask

    task automatic test_pulse0();
        logic [7:0] v;
        wr(5'd2, 8'd0);
        for (int i = 0; i < 8; i++) begin
            raise(1, (i >= 6) ? 3'd7 : 3'(i + 1));
            finish_seq("pulse0");
            wdt = 1'b0;
            tick(2);
        end
        wr(5'd1, 8'h5b);
        rd(5'd1, v); nvec++;
        if (v !== 8'h07) begin nmis++; $display("FAIL bad_magic: got %h want 07", v); end
        wr(5'd1, 8'h5a);
        wr(5'd0, 8'h01);
        wr(5'd2, 8'd4);
    endtask

    task automatic test_hold();
        int c;
        raise(4, 3'd1);
        finish_seq("hold1");
        c = irq_cnt;
        tick(30);
        nvec++;
        if (irq_cnt !== c || board_rst !== 1'b0) begin
            nmis++;
            $display("FAIL hold_retrig: got irqs=%0d rst=%b want %0d 0", irq_cnt, board_rst, c);
        end
        wdt = 1'b0;
        tick(2);
        raise(4, 3'd2);
        finish_seq("hold2");
        nvec++;
        if (irq_cnt !== c + 1) begin nmis++; $display("FAIL hold_irq2: got %0d want %0d", irq_cnt, c + 1); end
        wdt = 1'b0;
        tick(2);
    endtask

    task automatic test_en();
        logic [7:0] v;
        int c;
        wr(5'd0, 8'h00);
        c = irq_cnt;
        wdt = 1'b1;
        tick(10);
        nvec++;
        if (board_rst !== 1'b0 || irq_cnt !== c) begin
            nmis++;
            $display("FAIL en_off: got rst=%b irqs=%0d want 0 %0d", board_rst, irq_cnt, c);
        end
        rd(5'd1, v); nvec++;
        if (v !== 8'h02) begin nmis++; $display("FAIL en_tries: got %h want 02", v); end
        wdt = 1'b0;
        tick();
        wr(5'd0, 8'h01);
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        csr_a = 5'd1; csr_di = 8'h5a; csr_we = 1'b1;
        raise(4, 3'd1);
        csr_we = 1'b0;
        finish_seq("magic_bite");
        wdt = 1'b0; tick(2);
        csr_a = 5'd3; csr_di = 8'h01; csr_we = 1'b1;
        raise(4, 3'd2);
        csr_we = 1'b0;
        finish_seq("w1c_bite");
        rd(5'd3, v); nvec++;
        if (v !== 8'h01) begin nmis++; $display("FAIL w1c_bite_cause: got %h want 01", v); end
        wdt = 1'b0; tick(2);
        csr_a = 5'd0; csr_di = 8'h01; csr_we = 1'b1;
        raise(4, 3'd3);
        csr_we = 1'b0;
        nvec++;
        if (recovery !== 1'b1) begin nmis++; $display("FAIL recov_vs_sw: got %b want 1", recovery); end
        finish_seq("recov_bite");
        wdt = 1'b0; tick(2);
        raise(4, 3'd4);
        wr(5'd2, 8'd8);
        wr(5'd0, 8'h00);
        finish_seq("live_wr");
        wdt = 1'b0; tick(2);
        wr(5'd0, 8'h01);
        raise(8, 3'd5);
        finish_seq("new_pulse");
        wdt = 1'b0; tick(2);
    endtask

    task automatic test_rst_mid();
        logic [7:0] v;
        wr(5'd2, 8'd16);
        wdt = 1'b1;
        tick(6);
        nvec++;
        if (board_rst !== 1'b1) begin nmis++; $display("FAIL mid_pre: got %b want 1", board_rst); end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (board_rst !== 1'b0 || recovery !== 1'b0) begin
            nmis++;
            $display("FAIL async_rst: got rst,rec=%b want 00", {board_rst, recovery});
        end
        wdt = 1'b0;
        tick(2);
        rst = 1'b0;
        tick();
        rd(5'd0, v); nvec++;
        if (v !== 8'h01) begin nmis++; $display("FAIL mid_ctrl: got %h want 01", v); end
        rd(5'd1, v); nvec++;
        if (v !== 8'h00) begin nmis++; $display("FAIL mid_tries: got %h want 00", v); end
        rd(5'd2, v); nvec++;
        if (v !== 8'd16) begin nmis++; $display("FAIL mid_pulse: got %h want 10", v); end
        rd(5'd3, v); nvec++;
        if (v !== 8'h00) begin nmis++; $display("FAIL mid_cause: got %h want 00", v); end
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);
        test_reset();
        test_basic();
        test_recovery();
        test_pulse0();
        test_hold();
        test_en();
        test_back_to_back();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
